// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg -- configurable asynchronous serial (UART) receiver.
//
// Receives one frame (start, DATA_BITS data LSB first, optional parity,
// STOP_BITS stop bits) per falling edge on an idle-high line. Each bit is
// decided by a 3-sample majority vote around the middle of the bit period.
//
// Parameters
//   BAUD_END   clock cycles per bit period (>= 16)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  stop bits checked per frame (1 or 2)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   rs232_rx    asynchronous serial input, idles high
//   rx_data     last received data word (held until the next po_flag)
//   po_flag     one-cycle pulse marking a completed frame
//   parity_err  parity status of the frame flagged by po_flag
//   frame_err   stop-bit status of the frame flagged by po_flag
//   busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int BAUD_END  = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int MID   = BAUD_END / 2;
  localparam int CNT_W = $clog2(BAUD_END);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_END - 1);
  localparam logic [CNT_W-1:0] CNT_SMP0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_SMP1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(MID + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HI
  } state_t;

  state_t r_state;
  state_t w_next;

  // Input synchronizer and edge-detect history
  logic r_sync1, r_sync2, r_hist;
  // r_valid fills once r_sync2 carries a post-reset line value; r_armed is set
  // only after the line has been seen high, so a line that is already low when
  // reset releases cannot fake a start edge.
  logic [1:0] r_valid;
  logic       r_armed;

  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_bit_cnt;
  logic                 r_smp0, r_smp1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop_err;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_po_flag, r_parity_err, r_frame_err;

  logic w_fall, w_wrap, w_decide, w_vote;
  logic w_last_data, w_last_stop, w_stop_err, w_done;
  logic w_active, w_next_active;
  logic w_par_err;
  logic w_busy;

  assign w_fall      = r_armed & r_hist & ~r_sync2;
  assign w_wrap      = (r_cnt == CNT_LAST);
  assign w_decide    = (r_cnt == CNT_DECIDE);
  // Third sample is the live synchronized value at the decision count.
  assign w_vote      = (r_smp0 & r_smp1) | (r_smp0 & r_sync2) | (r_smp1 & r_sync2);
  assign w_last_data = (r_bit_cnt == 4'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == 4'(STOP_BITS - 1));
  // Earlier stop bits of this frame only count once bit_cnt has moved past 0.
  assign w_stop_err  = ~w_vote | ((r_bit_cnt != 4'd0) & r_stop_err);
  assign w_done      = (r_state == STOP) & w_decide & w_last_stop;

  assign w_active      = r_state inside {START, DATA, PAR, STOP};
  assign w_next_active = w_next inside {START, DATA, PAR, STOP};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge only, and every flop uses <= so
  // all sequential blocks see the same pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_next = START;
      START: begin
        if (w_decide && w_vote) w_next = IDLE;   // glitch: start bit read high
        else if (w_wrap)        w_next = DATA;
      end
      DATA:    if (w_wrap && w_last_data) w_next = (PARITY != 0) ? PAR : STOP;
      PAR:     if (w_wrap) w_next = STOP;
      STOP:    if (w_done) w_next = w_stop_err ? WAIT_HI : IDLE;
      WAIT_HI: if (r_sync2) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy = (r_state != IDLE);
  end

  always_comb begin
    w_par_err = 1'b0;
    if (PARITY == 1)      w_par_err = ~(^r_shift ^ r_par_bit);
    else if (PARITY == 2) w_par_err = ^r_shift ^ r_par_bit;
  end

  // ---------------------------------------------------------------------------
  // Datapath: synchronizer, baud/bit counters, sampling, result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_hist       <= 1'b1;
      r_valid      <= '0;
      r_armed      <= 1'b0;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_smp0       <= 1'b1;
      r_smp1       <= 1'b1;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_stop_err   <= 1'b0;
      r_rx_data    <= '0;
      r_po_flag    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1 <= rs232_rx;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_valid <= {r_valid[0], 1'b1};
      if (r_valid[1] && r_sync2) r_armed <= 1'b1;

      r_po_flag <= 1'b0;

      // Counter sits at 0 outside a frame, so entering START starts it at 0.
      if (w_active) r_cnt <= (w_wrap || !w_next_active) ? '0 : r_cnt + CNT_W'(1);
      else          r_cnt <= '0;

      if (r_cnt == CNT_SMP0) r_smp0 <= r_sync2;
      if (r_cnt == CNT_SMP1) r_smp1 <= r_sync2;

      case (r_state)
        START: if (w_wrap) r_bit_cnt <= '0;
        DATA: begin
          if (w_decide) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_wrap)   r_bit_cnt <= w_last_data ? 4'd0 : r_bit_cnt + 4'd1;
        end
        PAR: begin
          if (w_decide) r_par_bit <= w_vote;
          r_bit_cnt <= '0;
        end
        STOP: begin
          if (w_decide) r_stop_err <= w_stop_err;
          if (w_done) begin
            r_rx_data    <= r_shift;
            r_parity_err <= w_par_err;
            r_frame_err  <= w_stop_err;
            r_po_flag    <= 1'b1;
          end
          if (w_wrap) r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        default: r_bit_cnt <= '0;
      endcase
    end
  end

  assign rx_data    = r_rx_data;
  assign po_flag    = r_po_flag;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = w_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg -- self-checking bench for uart_rx_cfg.
//
// Three receivers share clk/rst, each with its own serial line:
//   inst 0: 8N1, inst 1: 8E1, inst 2: 8N2 (all BAUD_END = 56).
// Frames are built as bit lists from the data byte; the expected result
// (data, parity/frame status, po_flag cycle) is computed from the frame rules.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

  localparam int B   = 56;
  localparam int MID = B / 2;

  typedef struct packed {
    int         cyc;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line [3];
  logic [7:0] rxd  [3];
  logic       po   [3];
  logic       pe   [3];
  logic       fe   [3];
  logic       bsy  [3];
  logic       bsy_d[3];

  int cyc        = 0;
  int n_checks   = 0;
  int n_errors   = 0;
  int busy_rises [3] = '{0, 0, 0};

  ev_t exp_q [3][$];
  ev_t obs_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.BAUD_END(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst), .rs232_rx(line[0]), .rx_data(rxd[0]), .po_flag(po[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .busy(bsy[0]));

  uart_rx_cfg #(.BAUD_END(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst), .rs232_rx(line[1]), .rx_data(rxd[1]), .po_flag(po[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .busy(bsy[1]));

  uart_rx_cfg #(.BAUD_END(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .rst(rst), .rs232_rx(line[2]), .rx_data(rxd[2]), .po_flag(po[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .busy(bsy[2]));

  // Observe on the falling edge: log every po_flag and count busy rises.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (po[i] === 1'b1) begin
        ev_t ev;
        ev.cyc  = cyc;
        ev.data = rxd[i];
        ev.perr = pe[i];
        ev.ferr = fe[i];
        obs_q[i].push_back(ev);
      end
      if (bsy[i] === 1'b1 && bsy_d[i] !== 1'b1) busy_rises[i]++;
      bsy_d[i] = bsy[i];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame on line i and queue the expected result.
  // po_flag is due 3 cycles (sync + history) after the start drive, plus
  // (N-1) bit periods, plus MID + 2.
  task automatic send_frame(input int i, input int par_cfg, input int n_stop,
                            input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input bit glitch);
    logic bits [$];
    ev_t  e;
    int   cs;
    bits.push_back(1'b0);
    for (int j = 0; j < 8; j++) bits.push_back(d[j]);
    if (par_cfg != 0) bits.push_back(pbit);
    for (int j = 0; j < n_stop; j++) bits.push_back(stops[j]);
    cs     = cyc;
    e.cyc  = cs + 3 + (bits.size() - 1) * B + MID + 2;
    e.data = d;
    e.perr = (par_cfg == 1) ? ((^d ^ pbit) != 1'b1) :
             (par_cfg == 2) ? ((^d ^ pbit) != 1'b0) : 1'b0;
    e.ferr = (stops[0] == 1'b0) || (n_stop == 2 && stops[1] == 1'b0);
    exp_q[i].push_back(e);
    for (int k = 0; k < bits.size(); k++) begin
      line[i] = bits[k];
      if (glitch && k >= 1 && k <= 8) begin
        // Inverted for one cycle so it reaches the synchronized line at count MID.
        step(MID + 1);
        line[i] = ~bits[k];
        step(1);
        line[i] = bits[k];
        step(B - MID - 2);
      end else begin
        step(B);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) line[i] = 1'b1;
    rst = 1'b1;
    step(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({rxd[i], po[i], pe[i], fe[i], bsy[i]} !== 12'h000) begin
        n_errors++;
        $display("FAIL reset_outputs[%0d]: got data=%02h po=%b pe=%b fe=%b busy=%b, expected all 0",
                 i, rxd[i], po[i], pe[i], fe[i], bsy[i]);
      end
    end
    rst = 1'b0;
    step(2 * B);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bsy[i] !== 1'b0 || obs_q[i].size() != 0) begin
        n_errors++;
        $display("FAIL idle_after_reset[%0d]: got busy=%b frames=%0d, expected busy=0 frames=0",
                 i, bsy[i], obs_q[i].size());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4] = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    ev_t e, o;
    for (int k = 0; k < 4; k++) send_frame(0, 0, 1, bytes[k], 1'b0, 2'b11, 1'b0);
    step(4);
    n_checks++;
    if (obs_q[0].size() != exp_q[0].size()) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d frames, expected %0d", obs_q[0].size(), exp_q[0].size());
    end
    while (exp_q[0].size() > 0 && obs_q[0].size() > 0) begin
      e = exp_q[0].pop_front();
      o = obs_q[0].pop_front();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL b2b_frame: got cyc=%0d data=%02h pe=%b fe=%b, expected cyc=%0d data=%02h pe=%b fe=%b",
                 o.cyc, o.data, o.perr, o.ferr, e.cyc, e.data, e.perr, e.ferr);
      end
    end
    exp_q[0].delete();
    obs_q[0].delete();
    step(B);
    n_checks++;
    if (rxd[0] !== 8'hFF || po[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_hold: got data=%02h po=%b, expected data=ff po=0", rxd[0], po[0]);
    end
  endtask

  task automatic test_parity();
    ev_t e, o;
    logic [7:0] d;
    send_frame(1, 2, 1, 8'h07, 1'b1, 2'b11, 1'b0);
    send_frame(1, 2, 1, 8'h07, 1'b0, 2'b11, 1'b0);
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      send_frame(1, 2, 1, d, 1'($urandom), 2'b11, 1'b0);
    end
    step(4);
    n_checks++;
    if (obs_q[1].size() != exp_q[1].size()) begin
      n_errors++;
      $display("FAIL parity_count: got %0d frames, expected %0d", obs_q[1].size(), exp_q[1].size());
    end
    while (exp_q[1].size() > 0 && obs_q[1].size() > 0) begin
      e = exp_q[1].pop_front();
      o = obs_q[1].pop_front();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL parity_frame: got cyc=%0d data=%02h pe=%b fe=%b, expected cyc=%0d data=%02h pe=%b fe=%b",
                 o.cyc, o.data, o.perr, o.ferr, e.cyc, e.data, e.perr, e.ferr);
      end
    end
    exp_q[1].delete();
    obs_q[1].delete();
  endtask

  task automatic test_glitch_reject();
    int rises0 = busy_rises[0];
    line[0] = 1'b0;
    step(10);
    line[0] = 1'b1;
    step(B - 10);
    n_checks++;
    if (bsy[0] !== 1'b0 || busy_rises[0] != rises0 + 1) begin
      n_errors++;
      $display("FAIL glitch_busy: got busy=%b rises=%0d, expected busy=0 rises=%0d",
               bsy[0], busy_rises[0] - rises0, 1);
    end
    step(2 * B);
    n_checks++;
    if (obs_q[0].size() != 0) begin
      n_errors++;
      $display("FAIL glitch_noflag: got %0d frames, expected 0", obs_q[0].size());
    end
    obs_q[0].delete();
  endtask

  task automatic test_break();
    ev_t e, o;
    send_frame(2, 0, 2, 8'h3C, 1'b0, 2'b01, 1'b0);
    step(5 * B);
    n_checks++;
    if (bsy[2] !== 1'b1) begin
      n_errors++;
      $display("FAIL break_busy_low: got busy=%b, expected 1", bsy[2]);
    end
    line[2] = 1'b1;
    step(6);
    n_checks++;
    if (bsy[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL break_busy_high: got busy=%b, expected 0", bsy[2]);
    end
    send_frame(2, 0, 2, 8'($urandom), 1'b0, 2'b11, 1'b0);
    step(4);
    n_checks++;
    if (obs_q[2].size() != exp_q[2].size()) begin
      n_errors++;
      $display("FAIL break_count: got %0d frames, expected %0d", obs_q[2].size(), exp_q[2].size());
    end
    while (exp_q[2].size() > 0 && obs_q[2].size() > 0) begin
      e = exp_q[2].pop_front();
      o = obs_q[2].pop_front();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL break_frame: got cyc=%0d data=%02h pe=%b fe=%b, expected cyc=%0d data=%02h pe=%b fe=%b",
                 o.cyc, o.data, o.perr, o.ferr, e.cyc, e.data, e.perr, e.ferr);
      end
    end
    exp_q[2].delete();
    obs_q[2].delete();
  endtask

  task automatic test_glitch_data();
    ev_t e, o;
    send_frame(0, 0, 1, 8'($urandom), 1'b0, 2'b11, 1'b1);
    send_frame(0, 0, 1, 8'hA5, 1'b0, 2'b11, 1'b1);
    step(4);
    n_checks++;
    if (obs_q[0].size() != exp_q[0].size()) begin
      n_errors++;
      $display("FAIL gdata_count: got %0d frames, expected %0d", obs_q[0].size(), exp_q[0].size());
    end
    while (exp_q[0].size() > 0 && obs_q[0].size() > 0) begin
      e = exp_q[0].pop_front();
      o = obs_q[0].pop_front();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL gdata_frame: got cyc=%0d data=%02h pe=%b fe=%b, expected cyc=%0d data=%02h pe=%b fe=%b",
                 o.cyc, o.data, o.perr, o.ferr, e.cyc, e.data, e.perr, e.ferr);
      end
    end
    exp_q[0].delete();
    obs_q[0].delete();
  endtask

  task automatic test_reset_mid_frame();
    ev_t e, o;
    logic [7:0] d = 8'($urandom);
    int rises0;
    line[0] = 1'b0;
    step(B);
    for (int j = 0; j < 4; j++) begin
      line[0] = d[j];
      step(B);
    end
    line[0] = d[4];
    step(B / 2);
    rst = 1'b1;
    step(2);
    line[0] = 1'b1;
    rst = 1'b0;
    step(1);
    n_checks++;
    if ({rxd[0], po[0], pe[0], fe[0], bsy[0]} !== 12'h000) begin
      n_errors++;
      $display("FAIL midreset_outputs: got data=%02h po=%b pe=%b fe=%b busy=%b, expected all 0",
               rxd[0], po[0], pe[0], fe[0], bsy[0]);
    end
    step(3 * B);
    n_checks++;
    if (obs_q[0].size() != 0 || bsy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_noflag: got frames=%0d busy=%b, expected frames=0 busy=0",
               obs_q[0].size(), bsy[0]);
    end
    // Line already low when reset releases: no frame may start.
    rises0  = busy_rises[0];
    line[0] = 1'b0;
    rst     = 1'b1;
    step(2);
    rst = 1'b0;
    step(3 * B);
    n_checks++;
    if (busy_rises[0] != rises0 || obs_q[0].size() != 0) begin
      n_errors++;
      $display("FAIL lowline_nostart: got rises=%0d frames=%0d, expected rises=0 frames=0",
               busy_rises[0] - rises0, obs_q[0].size());
    end
    line[0] = 1'b1;
    step(B);
    send_frame(0, 0, 1, 8'h81, 1'b0, 2'b11, 1'b0);
    step(4);
    n_checks++;
    if (obs_q[0].size() != 1) begin
      n_errors++;
      $display("FAIL after_reset_count: got %0d frames, expected 1", obs_q[0].size());
    end
    while (exp_q[0].size() > 0 && obs_q[0].size() > 0) begin
      e = exp_q[0].pop_front();
      o = obs_q[0].pop_front();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL after_reset_frame: got cyc=%0d data=%02h pe=%b fe=%b, expected cyc=%0d data=%02h pe=%b fe=%b",
                 o.cyc, o.data, o.perr, o.ferr, e.cyc, e.data, e.perr, e.ferr);
      end
    end
    exp_q[0].delete();
    obs_q[0].delete();
  endtask

  task automatic test_random();
    ev_t e, o;
    for (int k = 0; k < 8; k++) begin
      send_frame(0, 0, 1, 8'($urandom), 1'b0, 2'b11, 1'b0);
      step($urandom_range(0, B));
    end
    step(4);
    n_checks++;
    if (obs_q[0].size() != exp_q[0].size()) begin
      n_errors++;
      $display("FAIL random_count: got %0d frames, expected %0d", obs_q[0].size(), exp_q[0].size());
    end
    while (exp_q[0].size() > 0 && obs_q[0].size() > 0) begin
      e = exp_q[0].pop_front();
      o = obs_q[0].pop_front();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL random_frame: got cyc=%0d data=%02h pe=%b fe=%b, expected cyc=%0d data=%02h pe=%b fe=%b",
                 o.cyc, o.data, o.perr, o.ferr, e.cyc, e.data, e.perr, e.ferr);
      end
    end
    exp_q[0].delete();
    obs_q[0].delete();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) line[i] = 1'b1;
    test_reset();
    test_back_to_back();
    test_parity();
    test_glitch_reject();
    test_break();
    test_glitch_data();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
